// File: rtl/cct_xyz_interp.sv
// CCT (Kelvin) to white-point XYZ: xy LUT lookup, linear interpolation, then
// X = x/y and Z = (1-x-y)/y through one shared restoring divider.
module cct_xyz_interp #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned N_NODES   = 12,
  parameter int unsigned CCT_MIN   = 3000,
  parameter int unsigned STEP_LOG2 = 9,
  parameter int unsigned Y_MIN     = 128,
  localparam int unsigned ADDR_W   = $clog2(N_NODES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            cct_in,
  input  logic                   cct_valid,
  output logic                   cct_ready,
  input  logic                   lut_we,
  input  logic [ADDR_W-1:0]      lut_addr,
  input  logic [2*FRAC_BITS-1:0] lut_wdata,
  output logic [3*DATA_W-1:0]    xyz_out,
  output logic                   xyz_valid,
  input  logic                   xyz_ready,
  output logic                   div_err
);

  localparam int unsigned CCT_MAX = CCT_MIN + ((N_NODES - 1) << STEP_LOG2);
  localparam int unsigned IW      = FRAC_BITS + STEP_LOG2 + 1;
  localparam int unsigned REM_W   = FRAC_BITS + 1;
  localparam int unsigned TRL_W   = REM_W + 1;
  localparam int unsigned DVD_W   = DATA_W + FRAC_BITS + 1;
  localparam int unsigned CNT_W   = $clog2(DATA_W);
  localparam int unsigned ONE     = 1 << FRAC_BITS;

  typedef enum logic [2:0] {IDLE, LOOKUP, INTERP, DIV_X, DIV_Z, OUT} state_t;

  state_t                 state_q, state_d;
  logic                   lk_q, lk_d;
  logic [15:0]            cct_q, cct_d;
  logic [ADDR_W-1:0]      idx0_q, idx0_d, idx1_q, idx1_d;
  logic [STEP_LOG2-1:0]   frac_q, frac_d;
  logic [FRAC_BITS-1:0]   x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [FRAC_BITS-1:0]   yd_q, yd_d;
  logic [REM_W-1:0]       zn_q, zn_d, rem_q, rem_d;
  logic [DATA_W-1:0]      quo_q, quo_d, xr_q, xr_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [3*DATA_W-1:0]    xyz_q, xyz_d;
  logic                   valid_q, valid_d, err_q, err_d;
  logic [2*FRAC_BITS-1:0] lut_q [N_NODES];
  logic [2*FRAC_BITS-1:0] lut_d [N_NODES];

  logic [15:0]            off;
  logic [ADDR_W-1:0]      node;
  logic [FRAC_BITS-1:0]   xi, yi;
  logic [REM_W-1:0]       sum;
  logic [TRL_W-1:0]       trial;
  logic                   step_ge;
  logic [REM_W-1:0]       rem_step;
  logic [DATA_W-1:0]      quo_step, div_res;
  logic                   pl_en;
  logic [REM_W-1:0]       pl_num;
  logic [FRAC_BITS-1:0]   pl_den;
  logic [DVD_W-1:0]       dvd;
  logic [REM_W-1:0]       hi;

  // a + floor((b-a)*f / 2^STEP_LOG2), signed arithmetic
  function automatic logic [FRAC_BITS-1:0] lerp(input logic [FRAC_BITS-1:0] a,
                                                 input logic [FRAC_BITS-1:0] b,
                                                 input logic [STEP_LOG2-1:0] f);
    logic signed [IW-1:0] d, p;
    d = $signed(IW'(b)) - $signed(IW'(a));
    p = (d * $signed(IW'(f))) >>> STEP_LOG2;
    return FRAC_BITS'(p + $signed(IW'(a)));
  endfunction

  always_comb begin
    state_d = state_q;  lk_d   = lk_q;   cct_d  = cct_q;
    idx0_d  = idx0_q;   idx1_d = idx1_q; frac_d = frac_q;
    x0_d    = x0_q;     x1_d   = x1_q;   y0_d   = y0_q;   y1_d = y1_q;
    yd_d    = yd_q;     zn_d   = zn_q;   rem_d  = rem_q;  quo_d = quo_q;
    ovf_d   = ovf_q;    cnt_d  = cnt_q;  xr_d   = xr_q;   xyz_d = xyz_q;
    valid_d = valid_q;  err_d  = err_q;  lut_d  = lut_q;
    cct_ready = 1'b0;
    pl_en  = 1'b0;
    pl_num = '0;
    pl_den = '0;

    off  = cct_q - 16'(CCT_MIN);
    node = ADDR_W'(off >> STEP_LOG2);
    xi   = lerp(x0_q, x1_q, frac_q);
    yi   = lerp(y0_q, y1_q, frac_q);
    sum  = REM_W'(xi) + REM_W'(yi);

    // one restoring-divide iteration: quotient bits shift in where dividend bits leave
    trial    = {rem_q, quo_q[DATA_W-1]};
    step_ge  = trial >= TRL_W'(yd_q);
    rem_step = step_ge ? REM_W'(trial - TRL_W'(yd_q)) : REM_W'(trial);
    quo_step = {quo_q[DATA_W-2:0], step_ge};
    div_res  = ovf_q ? '1 : quo_step;

    case (state_q)
      IDLE: begin
        cct_ready = ~lut_we & ~rst;
        if (lut_we) begin
          if (32'(lut_addr) < N_NODES) lut_d[lut_addr] = lut_wdata;
        end else if (cct_valid) begin
          if (32'(cct_in) < CCT_MIN)      cct_d = 16'(CCT_MIN);
          else if (32'(cct_in) > CCT_MAX) cct_d = 16'(CCT_MAX);
          else                            cct_d = cct_in;
          err_d   = 1'b0;
          lk_d    = 1'b0;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (!lk_q) begin
          idx0_d = node;
          frac_d = STEP_LOG2'(off);
          if (32'(node) == N_NODES - 1) begin
            idx1_d = node;
            frac_d = '0;
          end else begin
            idx1_d = node + ADDR_W'(1);
          end
          lk_d = 1'b1;
        end else begin
          x0_d    = lut_q[idx0_q][FRAC_BITS-1:0];
          y0_d    = lut_q[idx0_q][2*FRAC_BITS-1:FRAC_BITS];
          x1_d    = lut_q[idx1_q][FRAC_BITS-1:0];
          y1_d    = lut_q[idx1_q][2*FRAC_BITS-1:FRAC_BITS];
          state_d = INTERP;
        end
      end
      INTERP: begin
        if (32'(yi) < Y_MIN) begin
          err_d   = 1'b1;
          xyz_d   = {{DATA_W{1'b1}}, DATA_W'(ONE), {DATA_W{1'b1}}};
          valid_d = 1'b1;
          state_d = OUT;
        end else begin
          zn_d    = (32'(sum) >= ONE) ? '0 : REM_W'(ONE) - sum;
          pl_en   = 1'b1;
          pl_num  = REM_W'(xi);
          pl_den  = yi;
          cnt_d   = '0;
          state_d = DIV_X;
        end
      end
      DIV_X: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          xr_d    = div_res;
          err_d   = err_q | ovf_q;
          pl_en   = 1'b1;
          pl_num  = zn_q;
          pl_den  = yd_q;
          cnt_d   = '0;
          state_d = DIV_Z;
        end
      end
      DIV_Z: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          xyz_d   = {div_res, DATA_W'(ONE), xr_q};
          err_d   = err_q | ovf_q;
          valid_d = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (valid_q && xyz_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // divider preload; a high part >= y means the quotient cannot fit DATA_W bits
    dvd = DVD_W'(pl_num) << FRAC_BITS;
    hi  = dvd[DVD_W-1:DATA_W];
    if (pl_en) begin
      ovf_d = hi >= REM_W'(pl_den);
      rem_d = ovf_d ? '0 : hi;
      quo_d = dvd[DATA_W-1:0];
      yd_d  = pl_den;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  lk_q <= 1'b0;  cct_q <= '0;
      idx0_q  <= '0;    idx1_q <= '0;  frac_q <= '0;
      x0_q    <= '0;    x1_q <= '0;    y0_q <= '0;    y1_q <= '0;
      yd_q    <= '0;    zn_q <= '0;    rem_q <= '0;   quo_q <= '0;
      ovf_q   <= 1'b0;  cnt_q <= '0;   xr_q <= '0;    xyz_q <= '0;
      valid_q <= 1'b0;  err_q <= 1'b0;
      for (int i = 0; i < N_NODES; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;  lk_q <= lk_d;    cct_q <= cct_d;
      idx0_q  <= idx0_d;   idx1_q <= idx1_d; frac_q <= frac_d;
      x0_q    <= x0_d;     x1_q <= x1_d;    y0_q <= y0_d;   y1_q <= y1_d;
      yd_q    <= yd_d;     zn_q <= zn_d;    rem_q <= rem_d; quo_q <= quo_d;
      ovf_q   <= ovf_d;    cnt_q <= cnt_d;  xr_q <= xr_d;   xyz_q <= xyz_d;
      valid_q <= valid_d;  err_q <= err_d;
      for (int i = 0; i < N_NODES; i++) lut_q[i] <= lut_d[i];
    end
  end

  assign xyz_out   = xyz_q;
  assign xyz_valid = valid_q;
  assign div_err   = err_q;

endmodule

// File: tb/tb_cct_xyz_interp.sv
// Bench for cct_xyz_interp: directed test-plan cases plus randomized CCTs
// compared against an arithmetic model of lookup, interpolation and division.
module tb_cct_xyz_interp;

  localparam int NN = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cct_in = '0;
  logic        cct_valid = 1'b0;
  logic        cct_ready;
  logic        lut_we = 1'b0;
  logic [3:0]  lut_addr = '0;
  logic [31:0] lut_wdata = '0;
  logic [95:0] xyz_out;
  logic        xyz_valid;
  logic        xyz_ready = 1'b0;
  logic        div_err;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_lut [NN];

  cct_xyz_interp dut (
    .clk(clk), .rst(rst), .cct_in(cct_in), .cct_valid(cct_valid),
    .cct_ready(cct_ready), .lut_we(lut_we), .lut_addr(lut_addr),
    .lut_wdata(lut_wdata), .xyz_out(xyz_out), .xyz_valid(xyz_valid),
    .xyz_ready(xyz_ready), .div_err(div_err)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Expected {Z,Y,X}, error flag and accept-to-valid latency for one CCT
  function automatic void model(input int cct, output logic [95:0] xyz,
                                output logic err, output int lat);
    int c, off, idx, i1, fr, x0, x1, y0, y1, x, y, zn;
    longint qx, qz;
    c = (cct < 3000) ? 3000 : (cct > 8632) ? 8632 : cct;
    off = c - 3000;
    idx = off / 512;
    fr  = off % 512;
    i1  = idx + 1;
    if (idx == NN - 1) begin i1 = idx; fr = 0; end
    x0 = int'(m_lut[idx] & 32'hFFFF);  y0 = int'(m_lut[idx] >> 16);
    x1 = int'(m_lut[i1] & 32'hFFFF);   y1 = int'(m_lut[i1] >> 16);
    x = x0 + fdiv((x1 - x0) * fr, 512);
    y = y0 + fdiv((y1 - y0) * fr, 512);
    if (y < 128) begin
      xyz = {32'hFFFF_FFFF, 32'h0001_0000, 32'hFFFF_FFFF};
      err = 1'b1;
      lat = 3;
      return;
    end
    zn  = (x + y >= 65536) ? 0 : 65536 - x - y;
    qx  = (longint'(x) * 65536) / y;
    qz  = (longint'(zn) * 65536) / y;
    err = 1'b0;
    if (qx > 64'hFFFF_FFFF) begin qx = 64'hFFFF_FFFF; err = 1'b1; end
    if (qz > 64'hFFFF_FFFF) begin qz = 64'hFFFF_FFFF; err = 1'b1; end
    xyz = {qz[31:0], 32'h0001_0000, qx[31:0]};
    lat = 67;
  endfunction

  task automatic lut_write(input int addr, input logic [31:0] data);
    @(negedge clk);
    lut_addr = 4'(addr); lut_wdata = data; lut_we = 1'b1;
    @(negedge clk);
    lut_we = 1'b0;
    if (addr < NN) m_lut[addr] = data;
  endtask

  // Send one CCT and wait for the result; optionally leave it un-accepted
  task automatic convert(input int cct, input bit release_out, output logic [95:0] got,
                         output logic gerr, output int lat);
    int t;
    @(negedge clk);
    cct_in = 16'(cct); cct_valid = 1'b1;
    t = 0;
    while (!cct_ready && t < 300) begin @(negedge clk); t++; end
    checks++;
    if (t >= 300) begin
      failures++; $display("FAIL accept_timeout cct=%0d", cct);
    end
    @(posedge clk);
    lat = 0;
    forever begin
      @(negedge clk);
      cct_valid = 1'b0;
      if (xyz_valid || lat >= 300) break;
      @(posedge clk);
      lat++;
    end
    got = xyz_out; gerr = div_err;
    if (release_out) begin
      xyz_ready = 1'b1;
      @(negedge clk);
      xyz_ready = 1'b0;
    end
  endtask

  task automatic run_check(input string name, input int cct, output logic [95:0] got);
    logic [95:0] exp_xyz; logic exp_err, gerr; int exp_lat, lat;
    model(cct, exp_xyz, exp_err, exp_lat);
    convert(cct, 1'b1, got, gerr, lat);
    checks += 3;
    if (got !== exp_xyz) begin
      failures++; $display("FAIL %s_xyz cct=%0d got=%h exp=%h", name, cct, got, exp_xyz);
    end
    if (gerr !== exp_err) begin
      failures++; $display("FAIL %s_err cct=%0d got=%b exp=%b", name, cct, gerr, exp_err);
    end
    if (lat !== exp_lat) begin
      failures++; $display("FAIL %s_lat cct=%0d got=%0d exp=%0d", name, cct, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({xyz_out, xyz_valid, div_err, cct_ready} !== 99'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b exp=0", xyz_out, xyz_valid, div_err, cct_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < NN; i++) m_lut[i] = '0;
    @(negedge clk);
    checks++;
    if (cct_ready !== 1'b1) begin
      failures++; $display("FAIL idle_ready got=%b exp=1", cct_ready);
    end
  endtask

  task automatic test_single();
    logic [95:0] got;
    lut_write(0, {16'h54A7, 16'h5019});
    run_check("single", 3000, got);
    checks++;
    if (got !== {32'h0001_13F3, 32'h0001_0000, 32'h0000_F239}) begin
      failures++; $display("FAIL single_const got=%h exp=000113F3_00010000_0000F239", got);
    end
  endtask

  task automatic test_interp();
    logic [95:0] got;
    lut_write(0, {16'h8000, 16'h4000});
    lut_write(1, {16'h8000, 16'h6000});
    run_check("interp", 3256, got);
    checks++;
    if (got !== {32'h0000_6000, 32'h0001_0000, 32'h0000_A000}) begin
      failures++; $display("FAIL interp_const got=%h exp=00006000_00010000_0000A000", got);
    end
  endtask

  task automatic test_clamp();
    logic [95:0] lo, lo_ref, hi, hi_ref;
    for (int i = 0; i < NN; i++)
      lut_write(i, {16'($urandom_range(16'hFFFF, 16'h0800)), 16'($urandom_range(16'hFFFF, 0))});
    run_check("clamp_lo", 1000, lo);
    run_check("min", 3000, lo_ref);
    run_check("clamp_hi", 20000, hi);
    run_check("max", 8632, hi_ref);
    checks += 2;
    if (lo !== lo_ref) begin failures++; $display("FAIL clamp_lo_eq got=%h exp=%h", lo, lo_ref); end
    if (hi !== hi_ref) begin failures++; $display("FAIL clamp_hi_eq got=%h exp=%h", hi, hi_ref); end
  endtask

  task automatic test_random();
    logic [95:0] got;
    for (int i = 0; i < NN; i++)
      lut_write(i, {16'($urandom_range(16'hFFFF, 16'h0400)), 16'($urandom_range(16'hFFFF, 0))});
    lut_write(3, {16'($urandom_range(300, 0)), 16'($urandom_range(16'hFFFF, 0))});
    lut_write(13, 32'h0000_0000);
    for (int n = 0; n < 16; n++) run_check("random", int'($urandom_range(10000, 1500)), got);
    run_check("last_seg", 8500, got);
    run_check("node_edge", 3000 + 5 * 512, got);
  endtask

  task automatic test_div_err();
    logic [95:0] got;
    lut_write(0, {16'h0040, 16'h5019});
    run_check("diverr", 3000, got);
    lut_write(0, {16'h54A7, 16'h5019});
    run_check("diverr_clear", 3000, got);
  endtask

  task automatic test_backpressure();
    logic [95:0] got, dummy; logic gerr; int lat;
    lut_write(0, {16'h6000, 16'h3000});
    convert(3100, 1'b0, got, gerr, lat);
    cct_valid = 1'b1; cct_in = 16'd5000;
    lut_we = 1'b1; lut_addr = 4'd0; lut_wdata = 32'h0040_1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks += 3;
      if (xyz_out !== got) begin failures++; $display("FAIL bp_stable got=%h exp=%h", xyz_out, got); end
      if (cct_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", cct_ready); end
      if (xyz_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", xyz_valid); end
    end
    cct_valid = 1'b0; lut_we = 1'b0; xyz_ready = 1'b1;
    @(negedge clk);
    xyz_ready = 1'b0;
    checks++;
    if (xyz_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", xyz_valid); end
    run_check("bp_lut_kept", 3100, dummy);
  endtask

  task automatic test_reset_mid();
    logic [95:0] got;
    int t;
    @(negedge clk);
    cct_in = 16'd3000; cct_valid = 1'b1;
    t = 0;
    while (!cct_ready && t < 300) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk);
    cct_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({xyz_out, xyz_valid, div_err, cct_ready} !== 99'd0) begin
      failures++;
      $display("FAIL midrst_outputs got=%h/%b/%b/%b exp=0", xyz_out, xyz_valid, div_err, cct_ready);
    end
    for (int i = 0; i < NN; i++) m_lut[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    run_check("post_rst", 3000, got);
  endtask

  initial begin
    test_reset();
    test_single();
    test_interp();
    test_clamp();
    test_random();
    test_div_err();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
